// File: rtl/pipe_pal_reader.sv
// Read-side responder for the palette table: a registered request stage, a
// combinational table read with write-through bypass, and a 3-entry response FIFO.
module pipe_pal_reader #(
    parameter int unsigned W_DATA = 32,
    parameter int unsigned W_ADDR = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              i_clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [W_ADDR-1:0] wr_addr,
    input  logic [W_DATA-1:0] wr_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W_ADDR-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W_DATA-1:0] rsp_data,
    output logic              rsp_err
);

    logic [W_DATA-1:0] mem [DEPTH];

    logic              s1_valid;
    logic [W_ADDR-1:0] s1_addr;

    logic [W_DATA-1:0] fifo_data [3];
    logic              fifo_err  [3];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [1:0]        fifo_cnt;
    logic              ready_en;

    logic              accept;
    logic              push;
    logic              pop;
    logic              in_range;
    logic [W_DATA-1:0] push_data;
    logic [2:0]        occupancy;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Out-of-range addresses never match any implemented entry, so they
    // fall through as data 0 with err set.
    always_comb begin
        in_range  = 1'b0;
        push_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (s1_addr == i[W_ADDR-1:0]) begin
                in_range  = 1'b1;
                push_data = mem[i];
            end
        end
        if (in_range && wr_en && (wr_addr == s1_addr)) begin
            push_data = wr_data;
        end
    end

    // Occupancy counts the in-flight s1 slot so a push always finds room.
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, s1_valid};
    assign req_ready = ready_en && (occupancy < 3'd3);
    assign accept    = req_valid && req_ready;
    assign push      = s1_valid;
    assign rsp_valid = (fifo_cnt != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_data[rd_ptr];
    assign rsp_err   = fifo_err[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            for (int unsigned i = 0; i < 3; i++) begin
                fifo_data[i] <= '0;
                fifo_err[i]  <= 1'b0;
            end
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_en && (wr_addr == i[W_ADDR-1:0])) begin
                    mem[i] <= wr_data;
                end
            end

            s1_valid <= accept;
            if (accept) begin
                s1_addr <= req_addr;
            end

            if (push) begin
                fifo_data[wr_ptr] <= push_data;
                fifo_err[wr_ptr]  <= !in_range;
                wr_ptr            <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end

            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (resetn && push) begin
            assert (fifo_cnt != 2'd3);
        end
    end

endmodule

// File: tb/tb_pipe_pal_reader.sv
// Scoreboard bench for pipe_pal_reader: DEPTH=16 and DEPTH=12 instances share stimulus.
module tb_pipe_pal_reader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        req_valid;
    logic [3:0]  req_addr;
    logic        rsp_ready;

    logic        req_ready16, rsp_valid16, rsp_err16;
    logic [31:0] rsp_data16;
    logic        req_ready12, rsp_valid12, rsp_err12;
    logic [31:0] rsp_data12;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t q16[$];
    exp_t q12[$];
    exp_t e16, e12;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cnt = 0;

    pipe_pal_reader #(.W_DATA(32), .W_ADDR(4), .DEPTH(16)) dut16 (
        .i_clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .req_valid(req_valid), .req_ready(req_ready16), .req_addr(req_addr),
        .rsp_valid(rsp_valid16), .rsp_ready(rsp_ready), .rsp_data(rsp_data16), .rsp_err(rsp_err16)
    );

    pipe_pal_reader #(.W_DATA(32), .W_ADDR(4), .DEPTH(12)) dut12 (
        .i_clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .req_valid(req_valid), .req_ready(req_ready12), .req_addr(req_addr),
        .rsp_valid(rsp_valid12), .rsp_ready(rsp_ready), .rsp_data(rsp_data12), .rsp_err(rsp_err12)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every consumed response.
    always @(negedge clk) begin
        if (rsp_valid16 && rsp_ready) begin
            if (q16.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp16_unexpected: got data %0h, required no response", rsp_data16);
            end else begin
                e16 = q16.pop_front();
                chk("rsp16", {31'd0, rsp_err16, rsp_data16}, {31'd0, e16.err, e16.data});
                if (e16.lat) chk("latency16", 64'(cyc - e16.cyc), 64'd2);
            end
        end
        if (rsp_valid12 && rsp_ready) begin
            if (q12.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp12_unexpected: got data %0h, required no response", rsp_data12);
            end else begin
                e12 = q12.pop_front();
                chk("rsp12", {31'd0, rsp_err12, rsp_data12}, {31'd0, e12.err, e12.data});
            end
        end
    end

    // Issue one read; d is the hand-computed DEPTH=16 answer.
    task automatic rd(input logic [3:0] a, input logic [31:0] d, input bit lat);
        exp_t e;
        int t;
        req_valid = 1'b1;
        req_addr  = a;
        t = 0;
        @(negedge clk);
        while (!req_ready16 && t < 60) begin
            t++;
            @(negedge clk);
        end
        if (!req_ready16) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready 0 for addr %0d, required 1", a);
            @(posedge clk);
        end else begin
            e.data = d; e.err = 1'b0; e.cyc = cyc; e.lat = lat;
            @(posedge clk);
            q16.push_back(e);
            if (a >= 4'd12) begin
                e.data = '0;
                e.err  = 1'b1;
            end
            q12.push_back(e);
            acc_cnt++;
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q16.size() != 0 || q12.size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (q16.size() != 0 || q12.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", q16.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", {63'd0, rsp_valid16}, 64'd0);
        chk("reset_rsp_data", {32'd0, rsp_data16}, 64'd0);
        chk("reset_rsp_err", {63'd0, rsp_err16}, 64'd0);
        chk("reset_req_ready", {63'd0, req_ready16}, 64'd0);
        chk("reset_req_ready12", {63'd0, req_ready12}, 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_release_edge0", {63'd0, req_ready16}, 64'd0);
        @(negedge clk);
        chk("ready_after_release", {63'd0, req_ready16}, 64'd1);
        @(posedge clk);
        #1;

        // Cleared table, back-to-back, 2-cycle latency
        for (int i = 0; i < 16; i++) rd(4'(i), 32'h0, 1'b1);
        drain();

        for (int i = 0; i < 16; i++) wr(4'(i), 32'hA5A5_0000 + 32'(i));
        for (int i = 15; i >= 0; i--) rd(4'(i), 32'hA5A5_0000 + 32'(i), 1'b1);
        drain();

        // Back-pressure: exactly 3 accepts, stable head, in-order release
        rsp_ready = 1'b0;
        acc_cnt = 0;
        fork
            begin
                for (int i = 1; i <= 4; i++) rd(4'(i), 32'hA5A5_0000 + 32'(i), 1'b0);
            end
            begin
                for (int t = 0; t < 20 && acc_cnt < 3; t++) @(negedge clk);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_req_ready", {63'd0, req_ready16}, 64'd0);
                    chk("bp_head", {31'd0, rsp_valid16, rsp_data16}, {31'd0, 1'b1, 32'hA5A5_0001});
                end
                chk("bp_accepts", 64'(acc_cnt), 64'd3);
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        drain();

        // Write-through bypass in the s1 cycle, and a write one cycle too late
        wr(4'd5, 32'h11);
        rd(4'd5, 32'h22, 1'b1);
        wr(4'd5, 32'h22);
        drain();
        wr(4'd5, 32'h11);
        rd(4'd5, 32'h11, 1'b1);
        @(posedge clk);
        #1;
        wr(4'd5, 32'h33);
        drain();

        // Reset with 2 queued and 1 in s1: nothing may emerge, table cleared
        rsp_ready = 1'b0;
        rd(4'd6, 32'hA5A5_0006, 1'b0);
        rd(4'd7, 32'hA5A5_0007, 1'b0);
        rd(4'd8, 32'hA5A5_0008, 1'b0);
        resetn = 1'b0;
        q16.delete();
        q12.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("midreset_req_ready", {63'd0, req_ready16}, 64'd0);
        chk("midreset_rsp_valid", {63'd0, rsp_valid16}, 64'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_reset_quiet", {62'd0, rsp_valid16, rsp_valid12}, 64'd0);
        end
        @(posedge clk);
        #1;
        rd(4'd7, 32'h0, 1'b1);
        rd(4'd2, 32'h0, 1'b1);
        rd(4'd5, 32'h0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_pal_reader.md
# pipe_pal_reader

Read-side responder for the pipelined palette/register table. It holds a `DEPTH`-entry by `W_DATA` table that the upstream writer fills through a simple write port. It serves in-order read requests over a valid/ready request channel and returns data over a valid/ready response channel. It sits between the palette writer and downstream consumers, absorbing response back-pressure in a 3-entry output buffer.

## Interface
Parameters:
- `W_DATA`, 32, table word width.
- `W_ADDR`, 4, address width.
- `DEPTH`, 16, implemented entries; 1 ≤ `DEPTH` ≤ 2^`W_ADDR`.

Ports:
- `i_clk`  in  1  single clock; all logic on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  `W_ADDR`  write address.
- `wr_data`  in  `W_DATA`  write data.
- `req_valid`  in  1  read request valid.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_addr`  in  `W_ADDR`  read address.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_data`  out  `W_DATA`  read data.
- `rsp_err`  out  1  request address ≥ `DEPTH`.

## Operation
- Table:
  - Reset clears all entries to 0.
  - `wr_en` with `wr_addr` < `DEPTH` writes at the clock edge.
  - Writes with `wr_addr` ≥ `DEPTH` are dropped silently.
  - Writes during reset are ignored.
- Stage 1 (`s1`): an accepted request registers `req_addr` into `s1_addr` and sets `s1_valid`. With no accept, `s1_valid` clears.
- Stage 2: while `s1_valid`, the table is read combinationally at `s1_addr`, and {data, err} is pushed into the output FIFO at the next edge.
  - `s1_addr` ≥ `DEPTH`: push data 0, err 1.
  - `wr_en && wr_addr == s1_addr` in the same cycle: push `wr_data` (write-through bypass), err 0.
  - Otherwise: push the table word, err 0.
- Output FIFO:
  - 3 entries, in order.
  - `rsp_valid` = FIFO non-empty.
  - `rsp_data`/`rsp_err` come from the head entry.
  - Pop happens on `rsp_valid && rsp_ready`.
  - A push and a pop in the same cycle leave the count unchanged.
- Flow control:
  - `req_ready` = (`fifo_cnt` + `s1_valid`) < 3.
  - It is computed from registers only, with no combinational path from `req_valid` or `rsp_ready`.
  - This guarantees a push is never lost. Pushing into a full FIFO is a design error; flag it with an assertion.
- Ordering: responses are returned in exact request-accept order, one response per accepted request.

## Timing
- Reset values, applied at the first edge with `resetn`=0:
  - `s1_valid`=0, `fifo_cnt`=0, FIFO pointers=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0.
  - `req_ready`=1 from the cycle after reset deasserts. It is 0 while `resetn`=0.
- Latency: a request accepted at edge N shows `rsp_valid`=1 in the cycle after edge N+1, i.e. 2 cycles, when the FIFO was empty.
- Throughput: with `rsp_ready` held 1, one request per cycle is sustained indefinitely.
- Back-pressure: with `rsp_ready`=0, at most 3 requests are accepted beyond drained ones. After that `req_ready`=0 until a pop.
- Write visibility:
  - A write in the request cycle or in the `s1` cycle is returned.
  - A write one cycle after `s1` is not returned.
- Reset mid-operation: `s1` and FIFO contents are discarded and the table is cleared. No response for in-flight requests is ever emitted.
- Simultaneous push, pop and accept in one cycle are all legal. The count is updated as cnt + push − pop.
- `rsp_data`/`rsp_err` hold stable while `rsp_valid && !rsp_ready`.

## Test plan
- Reset, then read addresses 0..15 back-to-back with `rsp_ready`=1 → 16 responses of 0, `rsp_err`=0. First response 2 cycles after the first accept, then one per cycle.
- Write `0xA5A5_0000+i` to addresses 0..15, then read 15..0 → data returned in reverse order, exact values, with no bubbles.
- Hold `rsp_ready`=0 and drive `req_valid`=1 → exactly 3 accepts, then `req_ready`=0 and a stable head. Release `rsp_ready` → 3 in-order responses, and accepts resume.
- Accept a read of address 5 (holding 0x11), and in the `s1` cycle write 0x22 to address 5 → response 0x22. Repeat with the write one cycle later → 0x11.
- With `DEPTH`=12, read address 13 → `rsp_data`=0, `rsp_err`=1. Write address 13, then read it → still 0 with err 1.
- With 2 responses queued and 1 in `s1`, pulse `resetn`=0 for one cycle → no further `rsp_valid`. A subsequent read of any written address returns 0.
